mem_sync_responder: RTL

- Back-end row-transfer engine that answers the MEMSync tag-table FSM.
- When MEMSync is in WriteBack or Allocate, it moves one row between the cache channel array and backing memory, one beat at a time.
- It then pulses sync so that MEMSync leaves its state.
- Sits between MEMSync and the memory/cache data ports.

---
 rtl/mem_sync_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_sync_responder.sv
// Row-transfer engine behind the MEMSync tag table: moves one row between the
// cache channel array and backing memory beat by beat, then pulses sync.
module mem_sync_responder #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int BEATS     = 8,
    parameter int BWIDTH    = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_req,
    input  logic                 alloc_req,
    input  logic [CHWIDTH-1:0]   cRowId,
    input  logic [ADDRWIDTH-1:0] RowId,
    input  logic [ADDRWIDTH-1:0] victimRowId,
    input  logic                 mem_rdy,
    output logic                 sync,
    output logic                 busy,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic                 cache_rd_en,
    output logic                 cache_wr_en,
    output logic [ADDRWIDTH-1:0] mem_row,
    output logic [CHWIDTH-1:0]   cache_row,
    output logic [BWIDTH-1:0]    beat
);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        ALLOC,
        DONE,
        HOLD
    } state_t;

    localparam logic [BWIDTH-1:0] LAST_BEAT = BWIDTH'(BEATS - 1);

    state_t state;
    state_t state_nxt;
    logic   last_beat;

    assign last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= '0;
            mem_row   <= '0;
            cache_row <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Writeback has priority: the dirty victim must leave before the fill.
                    if (wb_req) begin
                        cache_row <= cRowId;
                        mem_row   <= victimRowId;
                        beat      <= '0;
                    end else if (alloc_req) begin
                        cache_row <= cRowId;
                        mem_row   <= RowId;
                        beat      <= '0;
                    end
                end
                WB, ALLOC: begin
                    if (mem_rdy) begin
                        beat <= last_beat ? '0 : beat + BWIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        sync        = 1'b0;
        busy        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        cache_rd_en = 1'b0;
        cache_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (wb_req) begin
                    state_nxt = WB;
                end else if (alloc_req) begin
                    state_nxt = ALLOC;
                end
            end
            WB: begin
                busy        = 1'b1;
                cache_rd_en = mem_rdy;
                mem_wr_en   = mem_rdy;
                if (mem_rdy && last_beat) begin
                    state_nxt = DONE;
                end
            end
            ALLOC: begin
                busy        = 1'b1;
                mem_rd_en   = mem_rdy;
                cache_wr_en = mem_rdy;
                if (mem_rdy && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                sync      = 1'b1;
                busy      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // Requests still high here are stale while MEMSync updates its state.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
